amber48_dmem_arbiter: RTL and testbench
=======================================

Name: amber48_dmem_arbiter

Overview:
Two-master arbiter in front of the single amber48 data-memory/MMIO port.
- Master 0 is the core load/store port; master 1 is a debug/loader requester (UART boot loader, bench backdoor).
- Round-robin arbitration, one outstanding transaction, registered request/response paths.
- A timeout watchdog converts a hung downstream into a trapped response.
- Sits between amber48_core and amber48_dmem in the top level.

Parameters:
TIMEOUT_CYCLES, 64, BUSY cycles allowed before forced trap response; 0 disables the watchdog
CNT_W, 8, width of timeout counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
m0_req_i  in  1  master 0 request, held until m0_ready_o
m0_we_i  in  1  master 0 write enable
m0_addr_i  in  XLEN  master 0 address
m0_wdata_i  in  XLEN  master 0 write data
m0_rdata_o  out  XLEN  master 0 read data, valid with m0_ready_o
m0_ready_o  out  1  master 0 completion pulse
m0_trap_o  out  1  master 0 access fault, valid with m0_ready_o
m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_rdata_o, m1_ready_o, m1_trap_o  same as m0_*, master 1
s_req_o  out  1  downstream request
s_we_o  out  1  downstream write enable
s_addr_o  out  XLEN  downstream address
s_wdata_o  out  XLEN  downstream write data
s_rdata_i  in  XLEN  downstream read data
s_ready_i  in  1  downstream completion
s_trap_i  in  1  downstream fault
grant_o  out  1  master of current/last transaction
busy_o  out  1  state != IDLE
timeout_o  out  1  one-cycle pulse when watchdog fires

Behaviour:
- Reset (rst_i high, async): state=IDLE, all outputs 0, timeout counter 0, last_q=1 so master 0 wins the first tie. Reset mid-transaction abandons it; no response is issued.
- States: IDLE, BUSY, RESP.
- IDLE:
  - Sample m0_req_i/m1_req_i. If only one is high, grant it. If both are high, grant !last_q.
  - On grant: latch we/addr/wdata into s_* registers, set grant_o and last_q to the winner, clear counter, go to BUSY.
  - If neither is requesting, stay in IDLE.
- BUSY:
  - s_req_o=1 with latched fields held stable.
  - On s_ready_i: capture s_rdata_i and s_trap_i, go to RESP.
  - Otherwise increment the counter. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without s_ready_i: capture rdata=0, trap=1, pulse timeout_o, go to RESP.
  - s_ready_i in the same cycle as expiry: ready wins; no timeout.
- RESP:
  - s_req_o=0.
  - Granted master sees mX_ready_o=1, mX_rdata_o=captured, mX_trap_o=captured for exactly one cycle. The other master's outputs stay 0.
  - Then go to IDLE.
- Latency: request sampled in cycle N → s_req_o in N+1 → s_ready_i in N+1 (best case) → mX_ready_o in N+2. Minimum 3-cycle transaction; next grant no earlier than N+3.
- Requester rule: keep req and fields stable until ready. Deassert req, or present a new request, in the cycle after ready. IDLE in N+3 therefore never sees a stale request.
- rdata/trap outputs are 0 whenever the corresponding ready is 0.
- s_ready_i or s_trap_i outside BUSY: ignored.
- Request changes by the non-granted master while a transaction is in flight: ignored; it is re-evaluated in IDLE.
- Fairness: under continuous requests from both masters, grants alternate 0,1,0,1. A lone requester is granted back-to-back every 3 cycles.

Decomposition:
- amber48_pkg gets:
  - typedef arb_state_e {ARB_IDLE, ARB_BUSY, ARB_RESP};
  - struct dmem_req_t {we, addr, wdata};
  - struct dmem_rsp_t {rdata, ready, trap}.
- XLEN comes from amber48_pkg.
- Single module; no sub-module warranted. Round-robin pick and timeout counter are inline.

Test Plan:
- m0 write addr 0x10 wdata 0xABC, s_ready_i asserted first BUSY cycle → s_req_o one cycle with addr 0x10/we=1; m0_ready_o pulses at N+2, m1_ready_o stays 0.
- m0 and m1 both request from reset, held continuously → grant order 0,1,0,1; each mX_ready_o pulses once per 3 cycles per grant pair.
- m1 read, downstream returns rdata 0x123456789ABC with s_trap_i=1 → m1_rdata_o=0x123456789ABC, m1_trap_o=1 for one cycle.
- TIMEOUT_CYCLES=4, s_ready_i never asserted → timeout_o pulse and m0_ready_o/m0_trap_o=1, m0_rdata_o=0 after 4 BUSY cycles; s_req_o drops; next request proceeds normally.
- s_ready_i coincident with timeout expiry → normal response, timeout_o stays 0.
- rst_i asserted during BUSY → s_req_o, busy_o, all ready outputs 0 immediately; after release, first tie grants master 0.

Source files
------------

// File: rtl/amber48_pkg.sv
// amber48_pkg: shared data-memory types for the amber48 data path.
package amber48_pkg;
    localparam int XLEN = 48;
    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_e;
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } dmem_req_t;
    typedef struct packed {
        logic [XLEN-1:0] rdata;
        logic            ready;
        logic            trap;
    } dmem_rsp_t;
endpackage

// File: rtl/amber48_dmem_arbiter_if.sv
// amber48_dmem_arbiter_if: both master ports, the downstream port and arbiter status.
interface amber48_dmem_arbiter_if;
    import amber48_pkg::*;
    logic            m0_req_i, m0_we_i, m0_ready_o, m0_trap_o;
    logic [XLEN-1:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
    logic            m1_req_i, m1_we_i, m1_ready_o, m1_trap_o;
    logic [XLEN-1:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
    logic            s_req_o, s_we_o, s_ready_i, s_trap_i;
    logic [XLEN-1:0] s_addr_o, s_wdata_o, s_rdata_i;
    logic            grant_o, busy_o, timeout_o;
    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        input  s_rdata_i, s_ready_i, s_trap_i,
        output m0_rdata_o, m0_ready_o, m0_trap_o,
        output m1_rdata_o, m1_ready_o, m1_trap_o,
        output s_req_o, s_we_o, s_addr_o, s_wdata_o,
        output grant_o, busy_o, timeout_o
    );
    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
        output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        output s_rdata_i, s_ready_i, s_trap_i,
        input  m0_rdata_o, m0_ready_o, m0_trap_o,
        input  m1_rdata_o, m1_ready_o, m1_trap_o,
        input  s_req_o, s_we_o, s_addr_o, s_wdata_o,
        input  grant_o, busy_o, timeout_o
    );
endinterface

// File: rtl/amber48_dmem_arbiter.sv
// amber48_dmem_arbiter: round-robin two-master arbiter with one outstanding access and a hang watchdog.
module amber48_dmem_arbiter
    import amber48_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input logic                   clk_i,
    input logic                   rst_i,
    amber48_dmem_arbiter_if.slave bus
);
    localparam bit               WD_EN   = TIMEOUT_CYCLES != 0;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);
    arb_state_e       state_q;
    dmem_req_t        req_q, pick;
    dmem_rsp_t        rsp_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q, grant_q, s_req_q, timeout_q, win, sel0, sel1;
    // On a tie the master that did not win last time goes next.
    assign win  = bus.m1_req_i & (~bus.m0_req_i | ~last_q);
    assign pick = win ? {bus.m1_we_i, bus.m1_addr_i, bus.m1_wdata_i}
                      : {bus.m0_we_i, bus.m0_addr_i, bus.m0_wdata_i};
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ARB_IDLE;
            req_q     <= '0;
            rsp_q     <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            grant_q   <= 1'b0;
            s_req_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    rsp_q     <= '0;
                    timeout_q <= 1'b0;
                    if (bus.m0_req_i | bus.m1_req_i) begin
                        req_q   <= pick;
                        grant_q <= win;
                        last_q  <= win;
                        cnt_q   <= '0;
                        s_req_q <= 1'b1;
                        state_q <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (bus.s_ready_i) begin
                        rsp_q   <= '{rdata: bus.s_rdata_i, ready: 1'b1, trap: bus.s_trap_i};
                        s_req_q <= 1'b0;
                        state_q <= ARB_RESP;
                    end else if (WD_EN && cnt_q == CNT_END) begin
                        rsp_q     <= '{rdata: '0, ready: 1'b1, trap: 1'b1};
                        timeout_q <= 1'b1;
                        s_req_q   <= 1'b0;
                        state_q   <= ARB_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ARB_RESP: begin
                    rsp_q     <= '0;
                    timeout_q <= 1'b0;
                    state_q   <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end
    assign sel0           = rsp_q.ready & ~grant_q;
    assign sel1           = rsp_q.ready & grant_q;
    assign bus.m0_ready_o = sel0;
    assign bus.m0_trap_o  = sel0 & rsp_q.trap;
    assign bus.m0_rdata_o = sel0 ? rsp_q.rdata : '0;
    assign bus.m1_ready_o = sel1;
    assign bus.m1_trap_o  = sel1 & rsp_q.trap;
    assign bus.m1_rdata_o = sel1 ? rsp_q.rdata : '0;
    assign bus.s_req_o    = s_req_q;
    assign bus.s_we_o     = req_q.we;
    assign bus.s_addr_o   = req_q.addr;
    assign bus.s_wdata_o  = req_q.wdata;
    assign bus.grant_o    = grant_q;
    assign bus.busy_o     = state_q != ARB_IDLE;
    assign bus.timeout_o  = timeout_q;
endmodule

// File: tb/tb_amber48_dmem_arbiter.sv
// tb_amber48_dmem_arbiter: directed checks of arbitration, responses, watchdog and reset.
module tb_amber48_dmem_arbiter;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    amber48_dmem_arbiter_if bus ();
    amber48_dmem_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
    always #5 clk_i = ~clk_i;
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        bus.m0_req_i = 0; bus.m0_we_i = 0; bus.m0_addr_i = '0; bus.m0_wdata_i = '0;
        bus.m1_req_i = 0; bus.m1_we_i = 0; bus.m1_addr_i = '0; bus.m1_wdata_i = '0;
        bus.s_ready_i = 0; bus.s_trap_i = 0; bus.s_rdata_i = '0;
        step();
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_sreq", bus.s_req_o, 0);
        chk("rst_grant", bus.grant_o, 0);
        chk("rst_m0_ready", bus.m0_ready_o, 0);
        rst_i = 0;
        step();
        // m0 write, downstream ready in the first BUSY cycle
        bus.m0_req_i = 1; bus.m0_we_i = 1; bus.m0_addr_i = 48'h10; bus.m0_wdata_i = 48'hABC;
        step();
        chk("wr_sreq", bus.s_req_o, 1);
        chk("wr_addr", bus.s_addr_o, 48'h10);
        chk("wr_we", bus.s_we_o, 1);
        chk("wr_wdata", bus.s_wdata_o, 48'hABC);
        chk("wr_grant", bus.grant_o, 0);
        bus.s_ready_i = 1;
        step();
        chk("wr_sreq_drop", bus.s_req_o, 0);
        chk("wr_m0_ready", bus.m0_ready_o, 1);
        chk("wr_m1_ready", bus.m1_ready_o, 0);
        chk("wr_m0_trap", bus.m0_trap_o, 0);
        bus.m0_req_i = 0; bus.s_ready_i = 0;
        step();
        chk("wr_idle_ready", bus.m0_ready_o, 0);
        chk("wr_idle_busy", bus.busy_o, 0);
        // fairness from reset with both masters requesting continuously
        rst_i = 1;
        bus.m0_req_i = 1; bus.m0_we_i = 0; bus.m0_addr_i = 48'h100;
        bus.m1_req_i = 1; bus.m1_we_i = 0; bus.m1_addr_i = 48'h200;
        bus.s_ready_i = 1;
        step();
        rst_i = 0;
        for (int k = 0; k < 4; k++) begin
            bus.s_rdata_i = 48'h1000 + 48'(k);
            step();
            chk("rr_grant", bus.grant_o, 64'(k % 2));
            chk("rr_addr", bus.s_addr_o, (k % 2) ? 48'h200 : 48'h100);
            step();
            chk("rr_m0_ready", bus.m0_ready_o, 64'((k % 2) == 0));
            chk("rr_m1_ready", bus.m1_ready_o, 64'((k % 2) == 1));
            chk("rr_rdata", (k % 2) ? bus.m1_rdata_o : bus.m0_rdata_o, 48'h1000 + 48'(k));
            chk("rr_other_rdata", (k % 2) ? bus.m0_rdata_o : bus.m1_rdata_o, 0);
            step();
            chk("rr_idle", bus.busy_o, 0);
        end
        // m1 read returning data with a fault
        bus.m0_req_i = 0; bus.s_ready_i = 0;
        bus.m1_req_i = 1; bus.m1_we_i = 0; bus.m1_addr_i = 48'h300;
        step();
        chk("rd_grant", bus.grant_o, 1);
        chk("rd_we", bus.s_we_o, 0);
        chk("rd_addr", bus.s_addr_o, 48'h300);
        bus.s_ready_i = 1; bus.s_trap_i = 1; bus.s_rdata_i = 48'h123456789ABC;
        step();
        chk("rd_m1_ready", bus.m1_ready_o, 1);
        chk("rd_m1_rdata", bus.m1_rdata_o, 48'h123456789ABC);
        chk("rd_m1_trap", bus.m1_trap_o, 1);
        chk("rd_m0_ready", bus.m0_ready_o, 0);
        chk("rd_m0_trap", bus.m0_trap_o, 0);
        bus.m1_req_i = 0; bus.s_ready_i = 0; bus.s_trap_i = 0; bus.s_rdata_i = 48'hDEAD;
        step();
        chk("rd_after_ready", bus.m1_ready_o, 0);
        chk("rd_after_rdata", bus.m1_rdata_o, 0);
        chk("rd_after_trap", bus.m1_trap_o, 0);
        // watchdog fires after four BUSY cycles without ready
        bus.m0_req_i = 1; bus.m0_addr_i = 48'h40;
        step();
        chk("to_c1_sreq", bus.s_req_o, 1);
        step();
        step();
        step();
        chk("to_c4_sreq", bus.s_req_o, 1);
        chk("to_c4_timeout", bus.timeout_o, 0);
        chk("to_c4_ready", bus.m0_ready_o, 0);
        step();
        chk("to_pulse", bus.timeout_o, 1);
        chk("to_m0_ready", bus.m0_ready_o, 1);
        chk("to_m0_trap", bus.m0_trap_o, 1);
        chk("to_m0_rdata", bus.m0_rdata_o, 0);
        chk("to_sreq_drop", bus.s_req_o, 0);
        bus.m0_req_i = 0;
        step();
        chk("to_pulse_end", bus.timeout_o, 0);
        bus.m0_req_i = 1; bus.m0_addr_i = 48'h44;
        step();
        chk("to_next_addr", bus.s_addr_o, 48'h44);
        bus.s_ready_i = 1; bus.s_rdata_i = 48'h55;
        step();
        chk("to_next_rdata", bus.m0_rdata_o, 48'h55);
        chk("to_next_trap", bus.m0_trap_o, 0);
        bus.m0_req_i = 0; bus.s_ready_i = 0;
        step();
        // ready on the same cycle the watchdog would expire
        bus.m0_req_i = 1; bus.m0_addr_i = 48'h48; bus.s_rdata_i = 48'h77;
        step();
        step();
        step();
        step();
        bus.s_ready_i = 1;
        step();
        chk("co_timeout", bus.timeout_o, 0);
        chk("co_ready", bus.m0_ready_o, 1);
        chk("co_trap", bus.m0_trap_o, 0);
        chk("co_rdata", bus.m0_rdata_o, 48'h77);
        bus.m0_req_i = 0; bus.s_ready_i = 0;
        step();
        // reset in the middle of an m0 transaction
        bus.m0_req_i = 1; bus.m0_addr_i = 48'h50;
        step();
        chk("mr_busy_before", bus.busy_o, 1);
        rst_i = 1;
        #1;
        chk("mr_sreq", bus.s_req_o, 0);
        chk("mr_busy", bus.busy_o, 0);
        chk("mr_m0_ready", bus.m0_ready_o, 0);
        chk("mr_m1_ready", bus.m1_ready_o, 0);
        bus.m1_req_i = 1; bus.m1_addr_i = 48'h60;
        #2;
        rst_i = 0;
        step();
        chk("mr_tie_grant", bus.grant_o, 0);
        chk("mr_tie_addr", bus.s_addr_o, 48'h50);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
